// File: rtl/priority_encoder_scan_display_pkg.sv
// Shared definitions for the priority encoder / scanned hex display family.
//   HEX_GLYPH : 7-segment glyphs for 0..F, bit order gfedcba, active high.
//               Entries 0..7 are the glyphs of the older octal-only decoder.
//   clog2     : ceiling log2, usable in parameter expressions.
package priority_encoder_scan_display_pkg;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b0111111, // 0
    7'b0000110, // 1
    7'b1011011, // 2
    7'b1001111, // 3
    7'b1100110, // 4
    7'b1101101, // 5
    7'b1111101, // 6
    7'b0000111, // 7
    7'b1111111, // 8
    7'b1101111, // 9
    7'b1110111, // A
    7'b1111100, // b
    7'b0111001, // C
    7'b1011110, // d
    7'b1111001, // E
    7'b1110001  // F
  };

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_scan_display_hex_to_7seg.sv
// Combinational hex digit to 7-segment glyph decoder.
//   nibble   : 4-bit value 0..F
//   segments : active-high segments, bit order gfedcba
module hex_to_7seg
  import priority_encoder_scan_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX_GLYPH[nibble];

endmodule

// File: rtl/priority_encoder_scan_display.sv
// Clocked priority encoder with a time-multiplexed hexadecimal display.
//   clk      : system clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   data     : asynchronous request bits, bit WIDTH-1 has highest priority
//   hold     : 1 freezes index/valid (synchroniser and scan keep running)
//   index    : registered index of the highest set request bit
//   valid    : registered, 1 when at least one request bit was set
//   segments : active-high segments of the lit digit, gfedcba
//   dp       : decimal point, lit on digit 0 when no request is present
//   digit_en : one-hot active-high digit enable, bit 0 = least significant nibble
//
// Pipeline: data -> sync1 -> sync2 -> index/valid -> segments/dp/digit_en.
// There is no handshake; outputs are free-running registered levels.
module priority_encoder_scan_display
  import priority_encoder_scan_display_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1,
  localparam int IDXW    = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1,
  localparam int DIGITS  = (IDXW + 3) / 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data,
  input  logic              hold,
  output logic [IDXW-1:0]   index,
  output logic              valid,
  output logic [6:0]        segments,
  output logic              dp,
  output logic [DIGITS-1:0] digit_en
);

  localparam int PTRW = (clog2(DIGITS) > 1) ? clog2(DIGITS) : 1;
  localparam int PADW = 4 * DIGITS;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [IDXW-1:0]  enc_idx;
  logic             enc_valid;
  logic [15:0]      scan_cnt;
  logic             scan_wrap;
  logic [PTRW-1:0]  ptr;
  logic [PADW-1:0]  idx_pad;
  logic [3:0]       nib;
  logic             upper_zero;
  logic [6:0]       glyph;

  // Per-bit two-flop synchroniser; bits are not coherent with each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= data;
      sync2 <= sync1;
    end
  end

  // Lowest index first, so the highest set bit overwrites earlier hits.
  always_comb begin
    enc_idx   = '0;
    enc_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i]) begin
        enc_idx   = IDXW'(i);
        enc_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      index <= enc_idx;
      valid <= enc_valid;
    end
  end

  // Scan timing: each digit stays selected for SCAN_DIV cycles.
  assign scan_wrap = (scan_cnt == 16'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      ptr      <= '0;
    end else begin
      scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      if (scan_wrap) begin
        ptr <= (ptr == PTRW'(DIGITS - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end

  // Select the nibble for the current digit and note whether it and every
  // more significant nibble are zero (a leading zero).
  always_comb begin
    idx_pad    = PADW'(index);
    nib        = 4'h0;
    upper_zero = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (PTRW'(d) == ptr) begin
        nib = idx_pad[4*d +: 4];
      end
      if ((PTRW'(d) >= ptr) && (idx_pad[4*d +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble   (nib),
    .segments (glyph)
  );

  // Display register; it lags the digit pointer by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments <= '0;
      dp       <= 1'b0;
      digit_en <= '0;
    end else begin
      digit_en <= DIGITS'(1) << ptr;
      if (!valid) begin
        segments <= '0;
        dp       <= (ptr == '0);
      end else if ((BLANK_LZ != 0) && (ptr != '0) && upper_zero) begin
        segments <= '0;
        dp       <= 1'b0;
      end else begin
        segments <= glyph;
        dp       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_scan_display.sv
// Directed bench for priority_encoder_scan_display: three instances cover
// the 64-input two-digit case, the single-digit WIDTH=2 corner and the
// 1024-input three-digit case without leading-zero blanking.
module tb_priority_encoder_scan_display;

  // Glyphs written out from the display table (gfedcba).
  localparam logic [6:0] G0 = 7'b0111111;
  localparam logic [6:0] G1 = 7'b0000110;
  localparam logic [6:0] G2 = 7'b1011011;
  localparam logic [6:0] G3 = 7'b1001111;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GC = 7'b0111001;
  localparam logic [6:0] GD = 7'b1011110;
  localparam logic [6:0] GF = 7'b1110001;
  localparam logic [6:0] BL = 7'b0000000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic [63:0]   data_m;
  logic          hold_m;
  logic [5:0]    idx_m;
  logic          valid_m;
  logic [6:0]    seg_m;
  logic          dp_m;
  logic [1:0]    de_m;

  logic [1:0]    data_s;
  logic [0:0]    idx_s;
  logic          valid_s;
  logic [6:0]    seg_s;
  logic          dp_s;
  logic [0:0]    de_s;

  logic [1023:0] data_w;
  logic [9:0]    idx_w;
  logic          valid_w;
  logic [6:0]    seg_w;
  logic          dp_w;
  logic [2:0]    de_w;

  logic          hold_off;

  priority_encoder_scan_display #(.WIDTH(64), .SCAN_DIV(4), .BLANK_LZ(1)) u_main (
    .clk(clk), .rst_n(rst_n), .data(data_m), .hold(hold_m),
    .index(idx_m), .valid(valid_m), .segments(seg_m), .dp(dp_m), .digit_en(de_m)
  );

  priority_encoder_scan_display #(.WIDTH(2), .SCAN_DIV(1), .BLANK_LZ(1)) u_small (
    .clk(clk), .rst_n(rst_n), .data(data_s), .hold(hold_off),
    .index(idx_s), .valid(valid_s), .segments(seg_s), .dp(dp_s), .digit_en(de_s)
  );

  priority_encoder_scan_display #(.WIDTH(1024), .SCAN_DIV(1), .BLANK_LZ(0)) u_wide (
    .clk(clk), .rst_n(rst_n), .data(data_w), .hold(hold_off),
    .index(idx_w), .valid(valid_w), .segments(seg_w), .dp(dp_w), .digit_en(de_w)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [2:0] cur_en(input int sel);
    case (sel)
      0:       return {1'b0, de_m};
      1:       return de_w;
      default: return {2'b00, de_s};
    endcase
  endfunction

  // Bounded wait for a given digit enable pattern; a timeout shows as a failed check.
  task automatic wait_en(input int sel, input logic [2:0] target);
    for (int i = 0; i < 32; i++) begin
      if (cur_en(sel) == target) break;
      tick(1);
    end
    check("wait_digit_en", 64'(cur_en(sel)), 64'(target));
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [63:0] data;
    logic [5:0]  idx;
    logic        valid;
    logic [6:0]  seg0;
    logic [6:0]  seg1;
    logic        dp0;
    logic        dp1;
  } vec_t;

  typedef struct {
    logic [1:0] data;
    logic [0:0] idx;
    logic       valid;
    logic [6:0] seg;
    logic       dp;
  } svec_t;

  vec_t  vecs[10];
  svec_t svecs[4];

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b1, GF, G3, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_0101, 6'd8,  1'b1, G8, BL, 1'b0, 1'b0};
    vecs[2] = '{64'h0000_0000_0000_0000, 6'd0,  1'b0, BL, BL, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0100_0000_0000, 6'd40, 1'b1, G8, G2, 1'b0, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_0001, 6'd0,  1'b1, G0, BL, 1'b0, 1'b0};
    vecs[5] = '{64'h0000_0000_0002_0008, 6'd17, 1'b1, G1, G1, 1'b0, 1'b0};
    vecs[6] = '{64'h0000_0000_8000_0000, 6'd31, 1'b1, GF, G1, 1'b0, 1'b0};
    vecs[7] = '{64'h0000_0000_0000_0400, 6'd10, 1'b1, GA, BL, 1'b0, 1'b0};
    vecs[8] = '{64'h0000_2000_0000_0000, 6'd45, 1'b1, GD, G2, 1'b0, 1'b0};
    vecs[9] = '{64'h0000_0000_0000_1000, 6'd12, 1'b1, GC, BL, 1'b0, 1'b0};

    svecs[0] = '{2'b10, 1'b1, 1'b1, G1, 1'b0};
    svecs[1] = '{2'b01, 1'b0, 1'b1, G0, 1'b0};
    svecs[2] = '{2'b00, 1'b0, 1'b0, BL, 1'b1};
    svecs[3] = '{2'b11, 1'b1, 1'b1, G1, 1'b0};

    hold_off = 1'b0;
    hold_m   = 1'b0;
    data_s   = '0;
    data_w   = '0;
    data_m   = '1;
    rst_n    = 1'b0;

    // ---- reset with all requests set ----
    tick(3);
    check("rst_index",    64'(idx_m),   64'd0);
    check("rst_valid",    64'(valid_m), 64'd0);
    check("rst_segments", 64'(seg_m),   64'd0);
    check("rst_dp",       64'(dp_m),    64'd0);
    check("rst_digit_en", 64'(de_m),    64'd0);

    rst_n = 1'b1;
    tick(1);
    check("first_edge_digit_en", 64'(de_m),  64'h1);
    tick(1);
    check("latency_edge2_index", 64'(idx_m), 64'd0);
    tick(1);
    check("latency_edge3_index", 64'(idx_m), 64'd63);
    check("latency_edge3_valid", 64'(valid_m), 64'd1);
    tick(1);
    check("scan_edge4_digit_en", 64'(de_m),  64'h1);
    tick(1);
    check("scan_edge5_digit_en", 64'(de_m),  64'h2);
    check("scan_edge5_seg",      64'(seg_m), 64'(G3));
    tick(3);
    check("scan_edge8_digit_en", 64'(de_m),  64'h2);
    tick(1);
    check("scan_edge9_digit_en", 64'(de_m),  64'h1);
    check("scan_edge9_seg",      64'(seg_m), 64'(GF));
    check("scan_edge9_dp",       64'(dp_m),  64'd0);

    // ---- table-driven vectors on the 64-input instance ----
    for (int i = 0; i < 10; i++) begin
      data_m = vecs[i].data;
      tick(3);
      check("vec_index", 64'(idx_m),   64'(vecs[i].idx));
      check("vec_valid", 64'(valid_m), 64'(vecs[i].valid));
      tick(1);
      wait_en(0, 3'b001);
      check("vec_seg_d0", 64'(seg_m), 64'(vecs[i].seg0));
      check("vec_dp_d0",  64'(dp_m),  64'(vecs[i].dp0));
      wait_en(0, 3'b010);
      check("vec_seg_d1", 64'(seg_m), 64'(vecs[i].seg1));
      check("vec_dp_d1",  64'(dp_m),  64'(vecs[i].dp1));
    end

    // ---- hold: freeze bit 40, change to bit 5, release ----
    data_m = 64'd1 << 40;
    tick(4);
    check("hold_pre_index", 64'(idx_m), 64'd40);
    hold_m = 1'b1;
    data_m = 64'd1 << 5;
    tick(6);
    check("hold_frozen_index", 64'(idx_m),   64'd40);
    check("hold_frozen_valid", 64'(valid_m), 64'd1);
    wait_en(0, 3'b010);
    check("hold_frozen_seg_d1", 64'(seg_m), 64'(G2));
    hold_m = 1'b0;
    tick(1);
    check("hold_release_index", 64'(idx_m), 64'd5);

    // ---- asynchronous reset while digit 1 is lit ----
    wait_en(0, 3'b010);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_segments", 64'(seg_m),   64'd0);
    check("async_rst_digit_en", 64'(de_m),    64'd0);
    check("async_rst_dp",       64'(dp_m),    64'd0);
    check("async_rst_index",    64'(idx_m),   64'd0);
    check("async_rst_valid",    64'(valid_m), 64'd0);
    #2;
    rst_n = 1'b1;
    tick(1);
    check("restart_edge1_digit_en", 64'(de_m), 64'h1);
    tick(3);
    check("restart_edge4_digit_en", 64'(de_m), 64'h1);
    tick(1);
    check("restart_edge5_digit_en", 64'(de_m), 64'h2);

    // ---- WIDTH=2, single digit, pointer never moves ----
    for (int i = 0; i < 4; i++) begin
      data_s = svecs[i].data;
      tick(4);
      check("small_index",    64'(idx_s),   64'(svecs[i].idx));
      check("small_valid",    64'(valid_s), 64'(svecs[i].valid));
      check("small_seg",      64'(seg_s),   64'(svecs[i].seg));
      check("small_dp",       64'(dp_s),    64'(svecs[i].dp));
      check("small_digit_en", 64'(de_s),    64'h1);
    end

    // ---- WIDTH=1024, no blanking, three digits ----
    data_w = '0;
    data_w[1023] = 1'b1;
    tick(4);
    check("wide_hi_index", 64'(idx_w),   64'd1023);
    check("wide_hi_valid", 64'(valid_w), 64'd1);
    wait_en(1, 3'b001);
    check("wide_hi_seg_d0", 64'(seg_w), 64'(GF));
    wait_en(1, 3'b010);
    check("wide_hi_seg_d1", 64'(seg_w), 64'(GF));
    wait_en(1, 3'b100);
    check("wide_hi_seg_d2", 64'(seg_w), 64'(G3));

    data_w = '0;
    data_w[0] = 1'b1;
    tick(4);
    check("wide_lo_index", 64'(idx_w),   64'd0);
    check("wide_lo_valid", 64'(valid_w), 64'd1);
    wait_en(1, 3'b001);
    check("wide_lo_seg_d0", 64'(seg_w), 64'(G0));
    wait_en(1, 3'b010);
    check("wide_lo_seg_d1", 64'(seg_w), 64'(G0));
    wait_en(1, 3'b100);
    check("wide_lo_seg_d2", 64'(seg_w), 64'(G0));
    check("wide_lo_dp_d2",  64'(dp_w),  64'd0);

    // ---- final report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
